save_slot_router: RTL and testbench
===================================

Name: save_slot_router

Overview:
- Generalised save-data front end for the bridge save path, running entirely in clk_74a.
- Serves NUM_SLOTS independent save slots. Each slot has a main memory region (sized from its RAM mask) followed by a fixed-length trailer region of TRAILER_WORDS words (RTC-style metadata).
- Publishes each slot's size to the APF datatable, routes loader writes and unloader reads to backing memory or the trailer, and signals completed trailer loads.
- Sits between the data_loader/data_unloader instances and the core's save RAM / RTC logic.

Parameters:
- NUM_SLOTS, 2, number of save slots.
- SLOT_ID_BASE, 1, datatable slot index of slot 0.
- ADDR_W, 18, byte address width per slot.
- WORD_BYTES, 2, bytes per memory word; must be 2 or 4.
- TRAILER_WORDS, 8, trailer length in words, per slot.
- DT_ADDR_W, 10, datatable address width.

Ports:
- clk_74a  in  1  clock
- reset  in  1  synchronous, active-high
- slot_en  in  NUM_SLOTS  slot has a save
- slot_mask  in  8*NUM_SLOTS  RAM mask per slot
- slot_trailer_en  in  NUM_SLOTS  slot carries a trailer
- wr_req  in  1  loader write strobe
- wr_slot  in  $clog2(NUM_SLOTS)  target slot of the write
- wr_addr  in  ADDR_W  byte address of the write
- wr_data  in  8*WORD_BYTES  write data
- rd_req  in  1  unloader read request
- rd_ready  out  1  read accepted this cycle
- rd_slot  in  $clog2(NUM_SLOTS)  target slot of the read
- rd_addr  in  ADDR_W  byte address of the read
- rd_data  out  8*WORD_BYTES  read data
- rd_valid  out  1  rd_data valid
- mem_wr  out  1  memory write enable
- mem_rd  out  1  memory read enable
- mem_slot  out  $clog2(NUM_SLOTS)  memory slot select
- mem_addr  out  ADDR_W-$clog2(WORD_BYTES)  word address
- mem_wdata  out  8*WORD_BYTES  memory write data
- mem_q  in  8*WORD_BYTES  memory read data, 1-cycle latency
- trailer_in  in  NUM_SLOTS*TRAILER_WORDS*8*WORD_BYTES  live trailer values
- trailer_out  out  same width  loaded trailer words
- trailer_loaded  out  NUM_SLOTS  one-cycle pulse per slot
- datatable_addr  out  DT_ADDR_W  datatable address
- datatable_wren  out  1  datatable write enable
- datatable_data  out  32  datatable write data

Behaviour:
- Size function:
  - If slot_en=0: size = 0.
  - Otherwise mask 01→512, 03→2048, 0F→8192, 3F→32768, 7F→65536, FF→131072; any other mask → 0.
  - pub_size = size + (slot_trailer_en ? TRAILER_WORDS*WORD_BYTES : 0).
- Publisher FSM, states IDLE, WRITE, GAP:
  - IDLE: scan index i cycles 0..NUM_SLOTS-1, one slot per cycle. If pub_size(i) != last(i), go to WRITE.
  - WRITE: for one cycle, drive datatable_wren=1, datatable_addr=(SLOT_ID_BASE+i)*2+1, datatable_data=pub_size(i), and set last(i)=pub_size(i). Then go to GAP.
  - GAP: one cycle with wren=0, then return to IDLE and continue at i+1.
  - last(i) resets to 32'hFFFFFFFF, so every slot is republished after reset.
- Write routing (combinational, same cycle):
  - Address below size: mem_wr=1, mem_addr=wr_addr>>log2(WORD_BYTES), mem_slot=wr_slot.
  - Address at or above size with trailer enabled: trailer index t=(wr_addr-size)/WORD_BYTES. If t<TRAILER_WORDS, write trailer_out[slot][t] on the next edge; otherwise drop.
  - Address at or above size with trailer disabled: drop.
  - A write to t=TRAILER_WORDS-1 pulses trailer_loaded[slot] one cycle later.
- Read path:
  - rd_ready = !wr_req; writes have priority.
  - On accept, mem_rd asserts only for reads below size.
  - Two-stage pipeline: rd_valid and rd_data appear exactly 2 cycles after acceptance.
  - Data source: mem_q for reads below size; trailer_in word t for trailer hits with t<TRAILER_WORDS; all-ones otherwise.
  - mem_addr/mem_slot select the write when wr_req=1, else the read.
- Size changes take effect on the next cycle; accesses in flight are not re-routed.
- Reset values: all outputs 0; trailer_out 0; pipeline flushed; FSM in IDLE with i=0. A reset mid-read drops the read, with no rd_valid.

Decomposition:
- save_slot_pkg holds:
  - function mask_to_size(mask) returning ADDR_W+1 bits;
  - publisher state enum;
  - localparam SIZE_SENTINEL.
- Sub-module save_slot_publisher contains the datatable FSM and the last() registers.

Test Plan:
- Reset, slot0 mask 0F with trailer, slot1 disabled, NUM_SLOTS=2, WORD_BYTES=2:
  - expect wren at addr 3 with data 8208;
  - expect wren at addr 5 with data 0;
  - expect no further writes.
- Change slot0 mask to 3F: expect exactly one write, addr 3, data 32784.
- wr_req slot0 at addr 0x1FFE: expect mem_wr=1, mem_addr 0x0FFF.
- wr_req slot0 at addr 0x2000 and 0x200E: expect no mem_wr, trailer words 0 and 7 updated, trailer_loaded[0] pulsed once.
- rd_req at addr 0x10 with mem_q=0xBEEF: expect rd_valid 2 cycles later with 0xBEEF.
- rd_req at 0x2002: expect trailer_in word1.
- rd_req at 0x2020: expect 0xFFFF.
- rd_req and wr_req in the same cycle: expect rd_ready=0 and the write issued.
- Reset asserted mid-read: expect no rd_valid and republish of both slots.

Source files
------------

// File: rtl/save_slot_pkg.sv
// Shared types and helpers for the save-slot router.
package save_slot_pkg;

    // Width of a decoded slot size (default ADDR_W of 18 plus one).
    localparam int unsigned SIZE_W = 19;

    // Reset value of the "last published" registers; never a legal size.
    localparam logic [31:0] SIZE_SENTINEL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        PUB_IDLE,
        PUB_WRITE,
        PUB_GAP
    } pub_state_t;

    // Where a read's data comes from once it leaves the pipeline.
    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_TRAILER,
        SRC_ONES
    } rd_src_t;

    // Byte size of the main memory region for a RAM mask; unknown masks map to 0.
    function automatic logic [SIZE_W-1:0] mask_to_size(input logic [7:0] mask);
        case (mask)
            8'h01:   mask_to_size = SIZE_W'(512);
            8'h03:   mask_to_size = SIZE_W'(2048);
            8'h0F:   mask_to_size = SIZE_W'(8192);
            8'h3F:   mask_to_size = SIZE_W'(32768);
            8'h7F:   mask_to_size = SIZE_W'(65536);
            8'hFF:   mask_to_size = SIZE_W'(131072);
            default: mask_to_size = '0;
        endcase
    endfunction

endpackage

// File: rtl/save_slot_router_publisher.sv
// Round-robin datatable publisher: writes a slot's size whenever it differs from the last value sent.
module save_slot_publisher
    import save_slot_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = 2,
    parameter int unsigned SLOT_ID_BASE = 1,
    parameter int unsigned DT_ADDR_W    = 10
) (
    input  logic                    clk_74a,
    input  logic                    reset,
    input  logic [NUM_SLOTS*32-1:0] pub_size,
    output logic [DT_ADDR_W-1:0]    datatable_addr,
    output logic                    datatable_wren,
    output logic [31:0]             datatable_data
);

    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    pub_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [31:0]      last [NUM_SLOTS];
    logic [31:0]      size_arr [NUM_SLOTS];

    // Unpack per-slot sizes and compute the wrapping scan index.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            size_arr[s] = pub_size[s*32 +: 32];
        end
        idx_next = (32'(idx) == NUM_SLOTS - 1) ? '0 : idx + 1'b1;
    end

    // Scan one slot per idle cycle; a changed size costs one write cycle plus one gap cycle.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state          <= PUB_IDLE;
            idx            <= '0;
            datatable_wren <= 1'b0;
            datatable_addr <= '0;
            datatable_data <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                last[s] <= SIZE_SENTINEL;
            end
        end else begin
            datatable_wren <= 1'b0;
            case (state)
                PUB_IDLE: begin
                    if (size_arr[idx] != last[idx]) begin
                        state          <= PUB_WRITE;
                        datatable_wren <= 1'b1;
                        datatable_addr <= DT_ADDR_W'((SLOT_ID_BASE + 32'(idx)) * 2 + 1);
                        datatable_data <= size_arr[idx];
                        last[idx]      <= size_arr[idx];
                    end else begin
                        idx <= idx_next;
                    end
                end
                PUB_WRITE: state <= PUB_GAP;
                PUB_GAP: begin
                    state <= PUB_IDLE;
                    idx   <= idx_next;
                end
                default: state <= PUB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/save_slot_router.sv
// Save-data front end: size publishing, loader write routing and unloader read pipeline.
module save_slot_router
    import save_slot_pkg::*;
#(
    parameter int unsigned NUM_SLOTS     = 2,
    parameter int unsigned SLOT_ID_BASE  = 1,
    parameter int unsigned ADDR_W        = 18,
    parameter int unsigned WORD_BYTES    = 2,
    parameter int unsigned TRAILER_WORDS = 8,
    parameter int unsigned DT_ADDR_W     = 10,
    localparam int unsigned SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int unsigned WORD_W    = 8 * WORD_BYTES,
    localparam int unsigned MADDR_W   = ADDR_W - $clog2(WORD_BYTES),
    localparam int unsigned TRAILER_W = NUM_SLOTS * TRAILER_WORDS * WORD_W
) (
    input  logic                   clk_74a,
    input  logic                   reset,
    input  logic [NUM_SLOTS-1:0]   slot_en,
    input  logic [8*NUM_SLOTS-1:0] slot_mask,
    input  logic [NUM_SLOTS-1:0]   slot_trailer_en,
    input  logic                   wr_req,
    input  logic [SLOT_W-1:0]      wr_slot,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic                   rd_req,
    output logic                   rd_ready,
    input  logic [SLOT_W-1:0]      rd_slot,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [WORD_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   mem_wr,
    output logic                   mem_rd,
    output logic [SLOT_W-1:0]      mem_slot,
    output logic [MADDR_W-1:0]     mem_addr,
    output logic [WORD_W-1:0]      mem_wdata,
    input  logic [WORD_W-1:0]      mem_q,
    input  logic [TRAILER_W-1:0]   trailer_in,
    output logic [TRAILER_W-1:0]   trailer_out,
    output logic [NUM_SLOTS-1:0]   trailer_loaded,
    output logic [DT_ADDR_W-1:0]   datatable_addr,
    output logic                   datatable_wren,
    output logic [31:0]            datatable_data
);

    localparam int unsigned BYTE_SH   = $clog2(WORD_BYTES);
    localparam int unsigned SZ_W      = ADDR_W + 1;
    localparam int unsigned TIDX_W    = (TRAILER_WORDS > 1) ? $clog2(TRAILER_WORDS) : 1;
    localparam int unsigned TRL_BYTES = TRAILER_WORDS * WORD_BYTES;

    logic [SZ_W-1:0]         size_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    trl_en_q;
    logic [NUM_SLOTS*32-1:0] pub_size;
    logic [WORD_W-1:0]       trl_q  [NUM_SLOTS][TRAILER_WORDS];
    logic [WORD_W-1:0]       trl_in [NUM_SLOTS][TRAILER_WORDS];

    logic [SZ_W-1:0]   wr_size, wr_off, wr_t, rd_size, rd_off, rd_t;
    logic              wr_below, wr_thit, rd_below, rd_thit, rd_acc;
    logic [TIDX_W-1:0] wr_tidx, rd_tidx;

    logic              s1_valid;
    rd_src_t           s1_src;
    logic [WORD_W-1:0] s1_tdata;

    // Sizes are sampled every cycle (reset included) so a mask change applies from the next cycle
    // and the first publish after reset already sees the configured sizes.
    always_ff @(posedge clk_74a) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            size_q[s] <= slot_en[s] ? SZ_W'(mask_to_size(slot_mask[8*s +: 8])) : '0;
        end
        trl_en_q <= slot_trailer_en;
    end

    // Published size includes the trailer when the slot carries one.
    always_comb begin
        pub_size = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            pub_size[s*32 +: 32] = 32'(size_q[s]) + (trl_en_q[s] ? 32'(TRL_BYTES) : 32'd0);
        end
    end

    // Pack/unpack trailer buses into per-slot word arrays.
    always_comb begin
        trailer_out = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int t = 0; t < TRAILER_WORDS; t++) begin
                trl_in[s][t] = trailer_in[(s*TRAILER_WORDS + t)*WORD_W +: WORD_W];
                trailer_out[(s*TRAILER_WORDS + t)*WORD_W +: WORD_W] = trl_q[s][t];
            end
        end
    end

    // Classify write and read addresses as main memory, trailer hit, or miss.
    always_comb begin
        wr_size  = size_q[wr_slot];
        wr_below = {1'b0, wr_addr} < wr_size;
        wr_off   = {1'b0, wr_addr} - wr_size;
        wr_t     = wr_off >> BYTE_SH;
        wr_thit  = !wr_below && trl_en_q[wr_slot] && (wr_t < SZ_W'(TRAILER_WORDS));
        wr_tidx  = wr_t[TIDX_W-1:0];
        rd_size  = size_q[rd_slot];
        rd_below = {1'b0, rd_addr} < rd_size;
        rd_off   = {1'b0, rd_addr} - rd_size;
        rd_t     = rd_off >> BYTE_SH;
        rd_thit  = !rd_below && trl_en_q[rd_slot] && (rd_t < SZ_W'(TRAILER_WORDS));
        rd_tidx  = rd_t[TIDX_W-1:0];
    end

    // Memory port: writes win the shared address/slot lines.
    assign rd_ready  = !reset && !wr_req;
    assign rd_acc    = rd_req && rd_ready;
    assign mem_wr    = !reset && wr_req && wr_below;
    assign mem_rd    = rd_acc && rd_below;
    assign mem_slot  = reset ? '0 : (wr_req ? wr_slot : rd_slot);
    assign mem_addr  = reset ? '0 : (wr_req ? wr_addr[ADDR_W-1:BYTE_SH] : rd_addr[ADDR_W-1:BYTE_SH]);
    assign mem_wdata = reset ? '0 : wr_data;

    // Capture trailer writes; the last trailer word marks the trailer as fully loaded.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            trailer_loaded <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                for (int t = 0; t < TRAILER_WORDS; t++) begin
                    trl_q[s][t] <= '0;
                end
            end
        end else begin
            trailer_loaded <= '0;
            if (wr_req && wr_thit) begin
                trl_q[wr_slot][wr_tidx] <= wr_data;
                if (32'(wr_tidx) == TRAILER_WORDS - 1) begin
                    trailer_loaded[wr_slot] <= 1'b1;
                end
            end
        end
    end

    // Two-stage read pipeline; the source is decided at accept so later size changes don't re-route it.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_src   <= SRC_ONES;
            s1_tdata <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            s1_src   <= rd_below ? SRC_MEM : (rd_thit ? SRC_TRAILER : SRC_ONES);
            s1_tdata <= trl_in[rd_slot][rd_tidx];
            rd_valid <= s1_valid;
            if (s1_valid) begin
                case (s1_src)
                    SRC_MEM:     rd_data <= mem_q;
                    SRC_TRAILER: rd_data <= s1_tdata;
                    default:     rd_data <= '1;
                endcase
            end
        end
    end

    save_slot_publisher #(
        .NUM_SLOTS   (NUM_SLOTS),
        .SLOT_ID_BASE(SLOT_ID_BASE),
        .DT_ADDR_W   (DT_ADDR_W)
    ) u_publisher (
        .clk_74a       (clk_74a),
        .reset         (reset),
        .pub_size      (pub_size),
        .datatable_addr(datatable_addr),
        .datatable_wren(datatable_wren),
        .datatable_data(datatable_data)
    );

endmodule

// File: tb/tb_save_slot_router.sv
// Randomized self-checking bench for save_slot_router against a behavioural model.
module tb_save_slot_router;

    localparam int unsigned NS = 2, AW = 18, WB = 2, TW = 8, DTW = 10, WW = 16;
    localparam int unsigned TRW = NS * TW * WW;

    logic              clk_74a = 1'b0;
    logic              reset;
    logic [NS-1:0]     slot_en, slot_trailer_en;
    logic [8*NS-1:0]   slot_mask;
    logic              wr_req, rd_req, rd_ready, rd_valid;
    logic [0:0]        wr_slot, rd_slot, mem_slot;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [WW-1:0]     wr_data, rd_data, mem_wdata;
    logic [WW-1:0]     mem_q = '0;
    logic              mem_wr, mem_rd;
    logic [AW-2:0]     mem_addr;
    logic [TRW-1:0]    trailer_in, trailer_out;
    logic [NS-1:0]     trailer_loaded;
    logic [DTW-1:0]    datatable_addr;
    logic              datatable_wren;
    logic [31:0]       datatable_data;

    always #5 clk_74a = ~clk_74a;

    save_slot_router dut (
        .clk_74a(clk_74a), .reset(reset),
        .slot_en(slot_en), .slot_mask(slot_mask), .slot_trailer_en(slot_trailer_en),
        .wr_req(wr_req), .wr_slot(wr_slot), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_slot(rd_slot), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_slot(mem_slot), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_q(mem_q),
        .trailer_in(trailer_in), .trailer_out(trailer_out), .trailer_loaded(trailer_loaded),
        .datatable_addr(datatable_addr), .datatable_wren(datatable_wren),
        .datatable_data(datatable_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- environment memory (driven by the DUT's memory port) ----------------
    logic [WW-1:0] env_mem [int];
    logic [WW-1:0] ref_mem [int];

    function automatic logic [WW-1:0] init_word(input int k);
        return 16'((k * 40503) ^ (k >> 7));
    endfunction

    always @(posedge clk_74a) begin
        int k;
        k = 32'(mem_slot) * 131072 + 32'(mem_addr);
        if (mem_rd) mem_q <= env_mem.exists(k) ? env_mem[k] : init_word(k);
        if (mem_wr) env_mem[k] = mem_wdata;
    end

    // ---------------- datatable monitor ----------------
    typedef struct { int addr; int data; } dt_t;
    dt_t dtq[$];
    bit  prev_wren = 1'b0;
    int  gap_viol  = 0;

    always @(negedge clk_74a) begin
        if (datatable_wren) begin
            dtq.push_back('{int'(datatable_addr), int'(datatable_data)});
            if (prev_wren) gap_viol++;
        end
        prev_wren = datatable_wren;
    end

    // ---------------- behavioural reference model ----------------
    typedef struct { int due; logic [WW-1:0] data; } rd_exp_t;
    rd_exp_t       rdq[$];
    logic [WW-1:0] tr_model [NS][TW];
    logic [NS-1:0] exp_loaded;
    int            cyc = 0;

    function automatic int slot_size(input int s);
        if (!slot_en[s]) return 0;
        case (slot_mask[8*s +: 8])
            8'h01: return 512;
            8'h03: return 2048;
            8'h0F: return 8192;
            8'h3F: return 32768;
            8'h7F: return 65536;
            8'hFF: return 131072;
            default: return 0;
        endcase
    endfunction

    function automatic int key_of(input int s, input int a);
        return s * 131072 + a / WB;
    endfunction

    function automatic logic [WW-1:0] ref_rd(input int k);
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_word(k);
    endfunction

    function automatic logic [WW-1:0] word_of(input logic [TRW-1:0] vec, input int idx);
        logic [TRW-1:0] v;
        v = vec >> (idx * WW);
        return v[WW-1:0];
    endfunction

    task automatic clear_model();
        rdq.delete();
        exp_loaded = '0;
        for (int s = 0; s < NS; s++)
            for (int t = 0; t < TW; t++) tr_model[s][t] = '0;
    endtask

    // One clock cycle: drive inputs, check same-cycle routing, advance model, check registered outputs.
    task automatic cycle(input bit w, input int ws, input int wa, input logic [WW-1:0] wd,
                         input bit r, input int rs, input int ra);
        int sz, t;
        logic [WW-1:0] e;
        bit rst, ev;
        rst = reset;
        wr_req = w; wr_slot = 1'(ws); wr_addr = AW'(wa); wr_data = wd;
        rd_req = r; rd_slot = 1'(rs); rd_addr = AW'(ra);
        #1;
        if (rst) begin
            check("rst_rd_ready", rd_ready, 0);
            check("rst_mem_wr", mem_wr, 0);
            check("rst_mem_rd", mem_rd, 0);
            check("rst_mem_addr", mem_addr, 0);
        end else begin
            check("rd_ready", rd_ready, !w);
            if (w) begin
                sz = slot_size(ws);
                check("mem_wr", mem_wr, wa < sz);
                check("mem_rd_blocked", mem_rd, 0);
                if (wa < sz) begin
                    check("mem_addr_w", mem_addr, wa / WB);
                    check("mem_slot_w", mem_slot, ws);
                    check("mem_wdata", mem_wdata, wd);
                    ref_mem[key_of(ws, wa)] = wd;
                end else if (slot_trailer_en[ws]) begin
                    t = (wa - sz) / WB;
                    if (t < TW) begin
                        tr_model[ws][t] = wd;
                        if (t == TW - 1) exp_loaded[ws] = 1'b1;
                    end
                end
            end else begin
                check("mem_wr_idle", mem_wr, 0);
                if (r) begin
                    sz = slot_size(rs);
                    check("mem_rd", mem_rd, ra < sz);
                    if (ra < sz) begin
                        check("mem_addr_r", mem_addr, ra / WB);
                        check("mem_slot_r", mem_slot, rs);
                        e = ref_rd(key_of(rs, ra));
                    end else begin
                        t = (ra - sz) / WB;
                        e = (slot_trailer_en[rs] && t < TW) ? word_of(trailer_in, rs * TW + t) : 16'hFFFF;
                    end
                    rdq.push_back('{cyc + 2, e});
                end else begin
                    check("mem_rd_idle", mem_rd, 0);
                end
            end
        end
        @(posedge clk_74a);
        cyc++;
        #1;
        if (rst) begin
            clear_model();
            check("rst_dt_wren", datatable_wren, 0);
        end
        ev = (rdq.size() > 0) && (rdq[0].due == cyc);
        check("rd_valid", rd_valid, ev);
        if (ev) begin
            check("rd_data", rd_data, rdq[0].data);
            void'(rdq.pop_front());
        end
        check("trailer_loaded", trailer_loaded, exp_loaded);
        exp_loaded = '0;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < TW; k++)
                check("trailer_out", word_of(trailer_out, s * TW + k), tr_model[s][k]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic check_pub(input string tag, input int n, input int a0, input int d0,
                             input int a1, input int d1);
        check({tag, "_count"}, dtq.size(), n);
        if (n >= 1 && dtq.size() >= 1) begin
            check({tag, "_addr0"}, dtq[0].addr, a0);
            check({tag, "_data0"}, dtq[0].data, d0);
        end
        if (n >= 2 && dtq.size() >= 2) begin
            check({tag, "_addr1"}, dtq[1].addr, a1);
            check({tag, "_data1"}, dtq[1].data, d1);
        end
        dtq.delete();
    endtask

    function automatic int gen_addr(input int s);
        int sz, sel;
        sz  = slot_size(s);
        sel = int'($urandom_range(0, 2));
        if (sel == 0 && sz > 0) return int'($urandom_range(0, sz - 1));
        if (sel == 1) return sz + int'($urandom_range(0, 39));
        return int'($urandom_range(0, 262143));
    endfunction

    task automatic random_ops(input int n);
        int ws, rs;
        for (int i = 0; i < n; i++) begin
            ws = int'($urandom_range(0, 1));
            rs = int'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) == 0, ws, gen_addr(ws), 16'($urandom()),
                  $urandom_range(0, 1) == 1, rs, gen_addr(rs));
        end
    endtask

    initial begin
        for (int i = 0; i < TRW / 32; i++) trailer_in[i*32 +: 32] = $urandom();
        slot_en         = 2'b01;
        slot_mask       = {8'h00, 8'h0F};
        slot_trailer_en = 2'b01;
        wr_req = 0; rd_req = 0; wr_slot = '0; rd_slot = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        clear_model();

        // Reset, then republish of both slots.
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        dtq.delete();
        idle(20);
        check_pub("pub_reset", 2, 3, 8208, 5, 0);

        // Single mask change produces exactly one write.
        slot_mask[7:0] = 8'h3F;
        idle(20);
        check_pub("pub_3f", 1, 3, 32784, 0, 0);
        slot_mask[7:0] = 8'h0F;
        idle(20);
        check_pub("pub_0f", 1, 3, 8208, 0, 0);

        // Directed writes: last main word, first and last trailer words.
        cycle(1, 0, 'h1FFE, 16'h1234, 0, 0, 0);
        cycle(1, 0, 'h2000, 16'hA001, 0, 0, 0);
        cycle(1, 0, 'h200E, 16'hA007, 0, 0, 0);
        idle(2);

        // Directed reads: memory, trailer word 1, beyond trailer.
        env_mem[key_of(0, 'h10)] = 16'hBEEF;
        ref_mem[key_of(0, 'h10)] = 16'hBEEF;
        cycle(0, 0, 0, '0, 1, 0, 'h10);
        cycle(0, 0, 0, '0, 1, 0, 'h2002);
        cycle(0, 0, 0, '0, 1, 0, 'h2020);
        idle(3);

        // Read and write in the same cycle: write wins.
        cycle(1, 0, 'h100, 16'h5A5A, 1, 0, 'h20);
        cycle(0, 0, 0, '0, 1, 0, 'h100);
        idle(3);

        // Random traffic, configuration A.
        slot_en   = 2'b11;
        slot_mask = {8'h03, 8'h0F};
        slot_trailer_en = 2'b11;
        idle(20);
        check_pub("pub_cfgA", 1, 5, 2064, 0, 0);
        random_ops(300);
        idle(3);

        // Random traffic, configuration B: slot1 unknown mask, slot0 without trailer.
        slot_mask[15:8] = 8'h05;
        idle(20);
        check_pub("pub_cfgB1", 1, 5, 16, 0, 0);
        slot_trailer_en[0] = 1'b0;
        idle(20);
        check_pub("pub_cfgB0", 1, 3, 8192, 0, 0);
        random_ops(300);
        idle(3);

        // Reset while a read is in flight: no rd_valid, both slots republished.
        cycle(0, 0, 0, '0, 1, 0, 'h10);
        reset = 1'b1;
        dtq.delete();
        idle(3);
        reset = 1'b0;
        idle(20);
        check_pub("pub_rerst", 2, 3, 8192, 5, 16);

        check("dt_gap", gap_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
